// File: rtl/mem_rsp_port.sv
// Handshaked memory responder: DEPTH x DATA_WIDTH array behind a valid/ready request port, in-order read responses.
// Latency: read data is presented one cycle after acceptance when the response FIFO is empty; writes take effect at the accept edge.
// Backpressure: a 2-entry response FIFO absorbs rsp_ready stalls; req_ready drops when it is full (registered count only).
module mem_rsp_port #(
  parameter int ADDR_WID   = 5,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WID-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  wr_err
);

  // Index width for the implemented entries; DEPTH <= 2**ADDR_WID keeps it within the address.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WID:0] DEPTH_L = DEPTH[ADDR_WID:0];

  // Storage and response FIFO state
  logic [DATA_WIDTH-1:0] r_mem      [DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_dat [2];
  logic                  r_fifo_err [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic                  r_wr_err;

  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wr_ok;
  logic                  w_wr_bad;
  logic [DATA_WIDTH-1:0] w_rd_dat;

  // Request decode. Out-of-range addresses are steered to entry 0 so the
  // array is never indexed past DEPTH; the read mux then forces zero data.
  always_comb begin
    w_in_range = ({1'b0, req_addr} < DEPTH_L);
    w_idx      = w_in_range ? req_addr[IDX_W-1:0] : '0;
    req_ready  = rst_n && (r_count < 2'd2);
    w_accept   = req_valid && req_ready;
    w_wr_ok    = w_accept && req_wr && w_in_range;
    w_wr_bad   = w_accept && req_wr && !w_in_range;
    w_push     = w_accept && !req_wr;
    w_pop      = rsp_valid && rsp_ready;
    w_rd_dat   = w_in_range ? r_mem[w_idx] : '0;
  end

  // Memory array: cleared on reset so no X ever reaches the response path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[w_idx] <= req_wdata;
    end
  end

  // Response FIFO storage and pointers; 1-bit pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fifo_dat[0] <= '0;
      r_fifo_dat[1] <= '0;
      r_fifo_err[0] <= 1'b0;
      r_fifo_err[1] <= 1'b0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_dat[r_wptr] <= w_rd_dat;
        r_fifo_err[r_wptr] <= !w_in_range;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Dropped out-of-range write flag, high for exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_wr_bad;
    end
  end

  // Head-of-FIFO presentation; the head entry is stable until popped.
  always_comb begin
    rsp_valid = (r_count != 2'd0);
    rsp_rdata = r_fifo_dat[r_rptr];
    rsp_err   = r_fifo_err[r_rptr];
    wr_err    = r_wr_err;
  end

endmodule

// File: tb/tb_mem_rsp_port.sv
module tb_mem_rsp_port;
  localparam int AW  = 5;
  localparam int DW  = 8;
  localparam int DEP = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          wr_err;

  mem_rsp_port #(.ADDR_WID(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents, queue of expected {err,data} responses.
  logic [DW-1:0] ref_mem [DEP];
  logic [DW:0]   sb [$];
  logic          exp_wr_err = 1'b0;
  bit            rand_rdy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor and model, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin
    logic acc;
    logic pop;
    chk("req_ready", {31'd0, req_ready}, {31'd0, rst_n && (sb.size() < 2)});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, sb.size() != 0});
    chk("wr_err", {31'd0, wr_err}, {31'd0, exp_wr_err});
    if (sb.size() != 0 && rsp_valid) begin
      chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, sb[0][DW-1:0]});
      chk("rsp_err", {31'd0, rsp_err}, {31'd0, sb[0][DW]});
    end
    if (!rst_n) begin
      for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
      sb.delete();
      exp_wr_err = 1'b0;
    end else begin
      pop = (sb.size() != 0) && rsp_ready;
      acc = req_valid && (sb.size() < 2);
      exp_wr_err = 1'b0;
      if (pop) void'(sb.pop_front());
      if (acc) begin
        if (req_wr) begin
          if (int'(req_addr) < DEP) ref_mem[int'(req_addr)] = req_wdata;
          else exp_wr_err = 1'b1;
        end else begin
          if (int'(req_addr) < DEP) sb.push_back({1'b0, ref_mem[int'(req_addr)]});
          else sb.push_back({1'b1, {DW{1'b0}}});
        end
      end
    end
  end

  // Random response backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rsp_ready = 1'($urandom % 2);
    end
  end

  task automatic wait_acc();
    int n = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout addr %0d: no req_ready within 100 cycles", req_addr);
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic wr, input int addr, input int wd);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr[AW-1:0];
    req_wdata = wd[DW-1:0];
    wait_acc();
  endtask

  initial begin
    int n;
    // Reset and post-reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("reset_err", {31'd0, rsp_err}, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Read every entry back-to-back: all zero, one per cycle
    rsp_ready = 1'b1;
    for (int i = 0; i < DEP; i++) do_req(1'b0, i, 0);
    repeat (3) @(posedge clk);
    #1;

    // Write mem[i]=i, then read-back and overwrite ordering
    for (int i = 0; i < DEP; i++) do_req(1'b1, i, i);
    do_req(1'b0, 5, 0);
    do_req(1'b1, 0, 'h72);
    do_req(1'b1, 0, 'h77);
    do_req(1'b0, 0, 0);
    repeat (3) @(posedge clk);
    #1;

    // Stall: two reads fill the FIFO, third waits, head holds
    rsp_ready = 1'b0;
    do_req(1'b0, 3, 0);
    do_req(1'b0, 4, 0);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 5'd7;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_head", {24'd0, rsp_rdata}, 32'h03);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_acc();
    repeat (3) @(posedge clk);
    #1;

    // Out-of-range read and write
    do_req(1'b0, 30, 0);
    do_req(1'b1, 25, 'hAA);
    do_req(1'b0, 25, 0);
    repeat (3) @(posedge clk);
    #1;

    // Mid-operation reset with two responses pending and a request presented
    rsp_ready = 1'b0;
    do_req(1'b0, 1, 0);
    do_req(1'b0, 2, 0);
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 5'd9;
    req_wdata = 8'h5A;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) do_req(1'b0, $urandom_range(0, DEP - 1), 0);
    do_req(1'b0, 9, 0);

    // Randomized traffic with random response backpressure
    rand_rdy = 1'b1;
    repeat (500) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
      do_req(1'($urandom % 2), $urandom_range(0, 31), $urandom_range(0, 255));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", sb.size(), 32'd0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_rsp_port.md
Name: mem_rsp_port

Overview:
- Handshaked responder front-end for a small synchronous memory.
- Accepts read/write requests on a valid/ready request channel and stores data in an internal DEPTH x DATA_WIDTH array.
- Returns read data in order on a valid/ready response channel, buffered by a 2-entry response FIFO so the requester may stall responses.
- Sits between a bus initiator (CPU-side or bench driver) and local storage; it is the responder end of the rd_en/wr_en/addr/data memory access interface, with flow control added.

Parameters:
- ADDR_WID, 5: request address width.
- DATA_WIDTH, 8: data word width.
- DEPTH, 24: implemented entries, 1 <= DEPTH <= 2**ADDR_WID. Addresses >= DEPTH are out of range.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WID  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  response at FIFO head is valid.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data of head response.
- rsp_err  output  1  head response was an out-of-range read.
- wr_err  output  1  one-cycle pulse: an out-of-range write was dropped.

Behaviour:
- Reset: on any rising edge with rst_n=0:
  - all DEPTH entries cleared to 0;
  - FIFO count=0, read and write pointers=0;
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0.
  - req_ready is 0 during reset cycles and 1 on the first cycle after rst_n returns high.
- Reset mid-operation: all pending responses are discarded with no partial output. Requests presented during reset are not accepted.
- Accept rule: a request is accepted on a rising edge where req_valid && req_ready. req_ready = (count < 2) and depends only on registered count; there is no combinational path from rsp_ready.
- req_ready gates writes too, so writes and reads complete strictly in acceptance order.
- Write, in range: mem[req_addr] <= req_wdata at the accept edge. No response is generated.
- Write, out of range: data dropped, memory unchanged, wr_err=1 for the following cycle only.
- Read, in range: mem[req_addr] is pushed into the FIFO at the accept edge with err=0.
- Read, out of range: data=0 and err=1 are pushed.
- Read latency: rsp_valid rises the cycle after acceptance when the FIFO was empty.
- Read-after-write: a write accepted at edge N followed by a read of the same address at edge N+1 returns the new data.
- Response channel:
  - Head entry is popped on an edge where rsp_valid && rsp_ready.
  - rsp_rdata and rsp_err hold stable while rsp_valid && !rsp_ready.
  - rsp_rdata and rsp_err are don't-care when rsp_valid=0, but are 0 after reset.
- FIFO count rules:
  - Push and pop on the same edge: count unchanged, order preserved.
  - Push only: count+1.
  - Pop only: count-1.
  - Pointers are 1 bit and wrap 1 -> 0.
  - Full (count=2): req_ready=0. Pop on a full edge makes req_ready=1 in the next cycle.
  - Empty: rsp_valid=0, and a rsp_ready pulse has no effect.
- Invariant: a write accepted while count=2 is impossible, because req_ready=0 blocks it.
- No X propagation: the array is fully initialised by reset. Out-of-range reads never index the array.

Test Plan:
- Reset, then read addr 0..DEPTH-1 back-to-back with rsp_ready=1 -> every response rdata=0x00, err=0, one response per cycle at 1-cycle latency.
- Write mem[i]=i for i=0..23, then read 5 -> rsp_rdata=0x05. Write addr 0 with 0x72, then 0x77, then read 0 -> rsp_rdata=0x77, not 0x72.
- Hold rsp_ready=0 and issue reads of 3, 4, 7 -> reads 3 and 4 accepted. req_ready=0 after the second accept and read 7 stalls. rsp_rdata stays 0x03. Raising rsp_ready delivers 0x03, 0x04, 0x07 in order.
- Read addr 30 (DEPTH=24) -> rsp_err=1, rsp_rdata=0x00. Write 0xAA to addr 25 -> wr_err pulses 1 cycle, and a read of 25 still returns err=1.
- With rsp_ready=1 and continuous reads, count stays 1 and req_ready stays 1 -> throughput of 1 response per cycle, with same-edge push/pop verified.
- Assert rst_n=0 for 1 cycle while 2 responses are pending -> rsp_valid=0 next cycle, no stale response afterwards, and a subsequent read of any address returns 0x00.
